pdm_cic_decimator: RTL



---
 rtl/pdm_cic_decimator_if.sv | 22 ++
 rtl/pdm_cic_decimator.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pdm_cic_decimator_if.sv
// PCM output stream of the CIC decimator: one-entry buffered valid/ready
// sample path plus the sticky overwrite flag.
interface pdm_cic_decimator_if;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        ovf;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready,
        output ovf
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready,
        input  ovf
    );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator turning a 1-bit PDM stream into 32-bit
// offset-binary PCM samples. Integrators run at the PDM bit rate (one step
// per detected ock rising edge), the comb section runs once per DECIM bits,
// and the result is saturated, left-justified and held in a one-entry
// output buffer with a sticky overwrite flag.
module pdm_cic_decimator #(
    parameter int DECIM = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ock,
    input  logic                       sdi,
    pdm_cic_decimator_if.master        pcm
);
    localparam int LOG2R = $clog2(DECIM);
    localparam int W     = 3 * LOG2R + 2;
    localparam int SW    = W - 1;
    localparam int PAD   = 32 - SW;

    localparam logic [LOG2R-1:0]    PH_LAST = LOG2R'(DECIM - 1);
    localparam logic signed [W-1:0] SAT_MAX = {2'b00, {(W-2){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {2'b11, {(W-2){1'b0}}};

    logic                    ock_d;
    logic                    ock_dd;
    logic                    ock_01;
    logic signed [W-1:0]     x_in;
    logic signed [W-1:0]     i1, i2, i3;
    logic signed [W-1:0]     i1_nxt, i2_nxt, i3_nxt;
    logic [LOG2R-1:0]        ph;
    logic                    dec_stb;
    logic signed [W-1:0]     d1, d2, d3;
    logic signed [W-1:0]     c1, c2, c3;
    logic signed [W-1:0]     c3_q;
    logic                    comb_stb;
    logic [SW-1:0]           s_val;
    logic [31:0]             pcm_word;
    logic [1:0]              warm_cnt;
    logic                    load;
    logic [31:0]             dout_q;
    logic                    dout_valid_q;
    logic                    ovf_q;

    assign ock_01 = ock_d & ~ock_dd;
    assign x_in   = sdi ? W'(1) : {W{1'b1}};

    // Bring the asynchronous PDM bit clock into the clk domain for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ock_d  <= 1'b0;
            ock_dd <= 1'b0;
        end else begin
            ock_d  <= ock;
            ock_dd <= ock_d;
        end
    end

    // Integrator cascade feeds each stage with the freshly updated previous stage.
    always_comb begin
        i1_nxt = i1 + x_in;
        i2_nxt = i2 + i1_nxt;
        i3_nxt = i3 + i2_nxt;
    end

    // Integrators and bit phase advance once per PDM bit; the last bit of a frame arms the comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            ph      <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= ock_01 && (ph == PH_LAST);
            if (ock_01) begin
                i1 <= i1_nxt;
                i2 <= i2_nxt;
                i3 <= i3_nxt;
                ph <= ph + LOG2R'(1);
            end
        end
    end

    // Comb differences against the values held from the previous decimation.
    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    // Comb section registers its result and delay taps once per decimated sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1       <= '0;
            d2       <= '0;
            d3       <= '0;
            c3_q     <= '0;
            comb_stb <= 1'b0;
        end else begin
            comb_stb <= dec_stb;
            if (dec_stb) begin
                d1   <= i3;
                d2   <= c1;
                d3   <= c2;
                c3_q <= c3;
            end
        end
    end

    // Clamp to one bit less than the accumulator width (only +R^3 can exceed it) and left-justify as offset binary.
    always_comb begin
        s_val = c3_q[SW-1:0];
        if (c3_q > SAT_MAX) begin
            s_val = SAT_MAX[SW-1:0];
        end else if (c3_q < SAT_MIN) begin
            s_val = SAT_MIN[SW-1:0];
        end
        pcm_word = {~s_val[SW-1], s_val[SW-2:0], {PAD{1'b0}}};
    end

    assign load = comb_stb && (warm_cnt == 2'd3);

    // Discard the first three filter outputs, then manage the one-entry buffer and sticky overwrite flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm_cnt     <= 2'd0;
            dout_q       <= 32'h8000_0000;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            if (comb_stb && (warm_cnt != 2'd3)) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            if (load) begin
                dout_q       <= pcm_word;
                dout_valid_q <= 1'b1;
                if (dout_valid_q && !pcm.dout_ready) begin
                    ovf_q <= 1'b1;
                end
            end else if (dout_valid_q && pcm.dout_ready) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign pcm.dout       = dout_q;
    assign pcm.dout_valid = dout_valid_q;
    assign pcm.ovf        = ovf_q;

endmodule
